// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
interface if_stage_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: IDLE/FETCH/STALL sequencer with branch redirect.
// Optional memory-timeout detector enabled by defining IF_FETCH_TIMEOUT_EN.
module if_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_freeze,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_address,
  if_stage_if.master  imem,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction,
  output logic        o_valid,
  output logic        o_fetch_error
);
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STALL} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_fpc, w_fpc_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_instr, w_instr_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_req;
  logic [XLEN-1:0] w_br_target;

  assign w_br_target = i_branch_address & ALIGN_MASK;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Branch beats freeze and any same-cycle ack; a frozen live instruction drops the ack.
  always_comb begin
    w_state_nxt = r_state;
    w_fpc_nxt   = r_fpc;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        if (i_branch_taken) w_fpc_nxt = w_br_target;
      end
      S_FETCH: begin
        if (i_branch_taken) begin
          w_fpc_nxt   = w_br_target;
          w_valid_nxt = 1'b0;
        end else if (r_valid && i_freeze) begin
          w_state_nxt = S_STALL;
        end else if (imem.imem_ack) begin
          w_instr_nxt = imem.imem_data;
          w_pc_nxt    = r_fpc + WORD_BYTES;
          w_fpc_nxt   = r_fpc + WORD_BYTES;
          w_valid_nxt = 1'b1;
        end
      end
      S_STALL: begin
        if (i_branch_taken) begin
          w_fpc_nxt   = w_br_target;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_FETCH;
        end else if (!i_freeze) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fpc   <= '0;
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      r_fpc   <= w_fpc_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_req   <= (w_state_nxt == S_FETCH);
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_fpc;
  assign o_pc           = r_pc;
  assign o_instruction  = r_instr;
  assign o_valid        = r_valid;

`ifdef IF_FETCH_TIMEOUT_EN
  localparam int unsigned TO_W = 4;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(14);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_fetch_error;
  logic            w_fetch_miss;

  // An unanswered request that stays in FETCH; any other cycle restarts the count.
  assign w_fetch_miss = (r_state == S_FETCH) && !i_branch_taken &&
                        !(r_valid && i_freeze) && !imem.imem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt      <= '0;
      r_fetch_error <= 1'b0;
    end else if (w_fetch_miss) begin
      if (r_to_cnt == TO_LAST) begin
        r_to_cnt      <= '0;
        r_fetch_error <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign o_fetch_error = r_fetch_error;
`else
  assign o_fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// compared against a behavioural fetch model.
module tb_if_stage;
  logic        clk;
  logic        rst;
  logic        freeze;
  logic        br;
  logic [31:0] br_addr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        valid;
  logic        ferr;

  int checks;
  int errors;

  if_stage_if bus ();

  if_stage dut (
    .clk              (clk),
    .rst              (rst),
    .i_freeze         (freeze),
    .i_branch_taken   (br),
    .i_branch_address (br_addr),
    .imem             (bus),
    .o_pc             (pc),
    .o_instruction    (instr),
    .o_valid          (valid),
    .o_fetch_error    (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: "started" = left reset idle; "stalled" = decode is holding a live word.
  logic        m_started, m_stalled, m_valid, m_err;
  logic [31:0] m_fpc, m_pc, m_instr;
  int          m_miss;

  function automatic void model_reset();
    m_started = 1'b0; m_stalled = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    m_fpc = 32'h0; m_pc = 32'h0; m_instr = 32'h0; m_miss = 0;
  endfunction

  function automatic void model_step(input logic fr, input logic b, input logic [31:0] ba,
                                     input logic ack, input logic [31:0] d);
    logic miss;
    miss = 1'b0;
    if (!m_started) begin
      if (b) m_fpc = {ba[31:2], 2'b00};
      m_started = 1'b1;
    end else if (b) begin
      m_fpc = {ba[31:2], 2'b00}; m_valid = 1'b0; m_stalled = 1'b0;
    end else if (m_stalled) begin
      if (!fr) m_stalled = 1'b0;
    end else if (m_valid && fr) begin
      m_stalled = 1'b1;
    end else if (ack) begin
      m_instr = d; m_fpc = m_fpc + 32'd4; m_pc = m_fpc; m_valid = 1'b1;
    end else begin
      miss = 1'b1;
    end
    if (miss) begin
      m_miss = m_miss + 1;
`ifdef IF_FETCH_TIMEOUT_EN
      if (m_miss == 15) begin m_err = 1'b1; m_miss = 0; end
`else
      if (m_miss == 15) m_miss = 0;
`endif
    end else begin
      m_miss = 0;
    end
  endfunction

  task automatic drive(input logic fr, input logic b, input logic [31:0] ba,
                       input logic ack, input logic [31:0] d);
    freeze = fr; br = b; br_addr = ba; bus.imem_ack = ack; bus.imem_data = d;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(freeze, br, br_addr, bus.imem_ack, bus.imem_data);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.imem_addr); end
    checks++; if (pc !== 32'h0 || instr !== 32'h0) begin errors++; $display("FAIL reset_pc_instr got %h/%h exp 0/0", pc, instr); end
    checks++; if (valid !== 1'b0 || ferr !== 1'b0) begin errors++; $display("FAIL reset_valid_err got %0b/%0b exp 0/0", valid, ferr); end
    rst = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL release_req got %0b exp 0", bus.imem_req); end
    cycle();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req got req=%0b addr=%h exp 1/0", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] d;
    for (int k = 1; k <= 8; k++) begin
      d = $urandom;
      drive(1'b0, 1'b0, 32'h0, 1'b1, d);
      cycle();
      checks++; if (pc !== 32'(4 * k) || instr !== d || valid !== 1'b1) begin
        errors++; $display("FAIL seq_out k=%0d got pc=%h ins=%h v=%0b exp %h/%h/1", k, pc, instr, valid, 32'(4 * k), d); end
      checks++; if (bus.imem_addr !== 32'(4 * k) || bus.imem_req !== 1'b1) begin
        errors++; $display("FAIL seq_addr k=%0d got %h req=%0b exp %h/1", k, bus.imem_addr, bus.imem_req, 32'(4 * k)); end
    end
  endtask

  task automatic test_freeze();
    logic [31:0] hp, hi, ha, d;
    hp = m_pc; hi = m_instr; ha = m_fpc;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
      cycle();
      checks++; if (bus.imem_req !== 1'b0 || pc !== hp || instr !== hi || bus.imem_addr !== ha) begin
        errors++; $display("FAIL freeze_hold k=%0d got req=%0b pc=%h ins=%h addr=%h exp 0/%h/%h/%h",
                           k, bus.imem_req, pc, instr, bus.imem_addr, hp, hi, ha); end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== ha) begin
      errors++; $display("FAIL freeze_resume got req=%0b addr=%h exp 1/%h", bus.imem_req, bus.imem_addr, ha); end
    d = $urandom;
    drive(1'b0, 1'b0, 32'h0, 1'b1, d);
    cycle();
    checks++; if (pc !== ha + 32'd4 || instr !== d) begin
      errors++; $display("FAIL freeze_next got pc=%h ins=%h exp %h/%h", pc, instr, ha + 32'd4, d); end
  endtask

  task automatic test_branch_ack();
    logic [31:0] hi, d;
    hi = m_instr;
    drive(1'b0, 1'b1, 32'h0000_0103, 1'b1, 32'hDEAD_BEEF);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (valid !== 1'b0 || bus.imem_addr !== 32'h100 || instr !== hi || bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL branch_drop got v=%0b addr=%h ins=%h req=%0b exp 0/00000100/%h/1",
                         valid, bus.imem_addr, instr, bus.imem_req, hi); end
    d = $urandom;
    drive(1'b0, 1'b0, 32'h0, 1'b1, d);
    cycle();
    checks++; if (pc !== 32'h104 || instr !== d || valid !== 1'b1) begin
      errors++; $display("FAIL branch_fetch got pc=%h ins=%h v=%0b exp 00000104/%h/1", pc, instr, valid, d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    drive(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0);
    cycle();
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_target got %h exp fffffffc", bus.imem_addr); end
    d = $urandom;
    drive(1'b0, 1'b0, 32'h0, 1'b1, d);
    cycle();
    checks++; if (pc !== 32'h0 || bus.imem_addr !== 32'h0 || instr !== d) begin
      errors++; $display("FAIL wrap got pc=%h addr=%h ins=%h exp 0/0/%h", pc, bus.imem_addr, instr, d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    model_step(freeze, br, br_addr, bus.imem_ack, bus.imem_data);
    #2;
    rst = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_data = 32'hCAFE_F00D;
    #1;
    model_reset();
    checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || pc !== 32'h0 ||
                  instr !== 32'h0 || valid !== 1'b0 || ferr !== 1'b0) begin
      errors++; $display("FAIL async_reset got req=%0b addr=%h pc=%h ins=%h v=%0b e=%0b exp all 0",
                         bus.imem_req, bus.imem_addr, pc, instr, valid, ferr); end
    @(negedge clk);
    rst = 1'b1;
    cycle();
    checks++; if (valid !== 1'b0 || instr !== 32'h0 || pc !== 32'h0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL late_ack got v=%0b ins=%h pc=%h req=%0b addr=%h exp 0/0/0/1/0",
                         valid, instr, pc, bus.imem_req, bus.imem_addr); end
    d = $urandom;
    drive(1'b0, 1'b0, 32'h0, 1'b1, d);
    cycle();
    checks++; if (pc !== 32'h4 || instr !== d || valid !== 1'b1) begin
      errors++; $display("FAIL refetch got pc=%h ins=%h v=%0b exp 4/%h/1", pc, instr, valid, d); end
  endtask

  task automatic test_timeout();
    logic exp_err;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      cycle();
`ifdef IF_FETCH_TIMEOUT_EN
      exp_err = (k >= 15);
`else
      exp_err = 1'b0;
`endif
      checks++; if (ferr !== exp_err || bus.imem_req !== 1'b1) begin
        errors++; $display("FAIL timeout k=%0d got err=%0b req=%0b exp %0b/1", k, ferr, bus.imem_req, exp_err); end
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
      cycle();
    end
    checks++; if (ferr !== m_err) begin
      errors++; $display("FAIL timeout_sticky got %0b exp %0b", ferr, m_err); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom,
            $urandom_range(0, 4) < 3, $urandom);
      cycle();
      checks++; if (bus.imem_req !== (m_started && !m_stalled)) begin
        errors++; $display("FAIL rnd_req n=%0d got %0b exp %0b", n, bus.imem_req, m_started && !m_stalled); end
      checks++; if (bus.imem_addr !== m_fpc) begin
        errors++; $display("FAIL rnd_addr n=%0d got %h exp %h", n, bus.imem_addr, m_fpc); end
      checks++; if (pc !== m_pc || instr !== m_instr) begin
        errors++; $display("FAIL rnd_pc_ins n=%0d got %h/%h exp %h/%h", n, pc, instr, m_pc, m_instr); end
      checks++; if (valid !== m_valid || ferr !== m_err) begin
        errors++; $display("FAIL rnd_valid_err n=%0d got %0b/%0b exp %0b/%0b", n, valid, ferr, m_valid, m_err); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 32'h0;
    test_reset();
    test_sequential();
    test_freeze();
    test_branch_ack();
    test_wrap();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
